// File: rtl/ac_ostream_sched_if.sv
// Buffer-read and AXI-Stream signal bundle for ac_ostream_sched.
// The scheduler uses the master modport and the buffer/sink environment uses the slave modport.
interface ac_ostream_sched_if #(
    parameter int DATA_WIDTH = 24,
    parameter int N_PARALLEL = 2
);
    localparam int W = DATA_WIDTH * N_PARALLEL;

    logic         buf_empty;
    logic         buf_rd;
    logic [W-1:0] buf_rdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [W-1:0] m_axis_tdata;
    logic         m_axis_tlast;
    logic         m_axis_tuser;

    modport master (
        input  buf_empty, buf_rdata, m_axis_tready,
        output buf_rd, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser
    );

    modport slave (
        output buf_empty, buf_rdata, m_axis_tready,
        input  buf_rd, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/ac_ostream_sched.sv
// Drains the wide output buffer onto an AXI-Stream master, framing beats into rows (tlast) and frames (tuser).
// Defining AC_OSTREAM_STALL_CNT_EN adds a 32-bit saturating stall_cycles output.
module ac_ostream_sched #(
    parameter int DATA_WIDTH     = 24,
    parameter int N_PARALLEL     = 2,
    parameter int DST_IMG_WIDTH  = 4096,
    parameter int DST_IMG_HEIGHT = 2160
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    ac_ostream_sched_if.master bus,
    output logic               busy,
    output logic               frame_done
`ifdef AC_OSTREAM_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);
    localparam int W             = DATA_WIDTH * N_PARALLEL;
    localparam int BEATS_PER_ROW = DST_IMG_WIDTH / N_PARALLEL;
    localparam int TOTAL_BEATS   = BEATS_PER_ROW * DST_IMG_HEIGHT;
    localparam int COL_W         = $clog2(BEATS_PER_ROW);
    localparam int ROW_W         = $clog2(DST_IMG_HEIGHT);
    localparam int ISS_W         = $clog2(TOTAL_BEATS + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [ISS_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [COL_W-1:0]   col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0]   row_cnt_q, row_cnt_d;
    logic               inflight_q;
    logic               out_vld_q, out_vld_d, spare_vld_q, spare_vld_d;
    logic [W-1:0]       out_data_q, out_data_d, spare_data_q, spare_data_d;

    logic       hs, pop, start_acc, last_col, last_row, frame_end;
    logic [1:0] credit;

    assign start_acc = start & (state_q == S_IDLE);
    assign hs        = out_vld_q & bus.m_axis_tready;
    assign last_col  = (col_cnt_q == COL_W'(BEATS_PER_ROW - 1));
    assign last_row  = (row_cnt_q == ROW_W'(DST_IMG_HEIGHT - 1));
    assign frame_end = hs & last_col & last_row;

    // Words held in staging plus the one popped last cycle that lands this cycle.
    assign credit = 2'(out_vld_q) + 2'(spare_vld_q) + 2'(inflight_q);
    assign pop    = (state_q == S_RUN) & ~bus.buf_empty &
                    ((credit < 2'd2) | ((credit == 2'd2) & hs));

    // NOTE: async active-low reset and non-blocking assignments for every register; the staging
    // data registers are reset too so that tdata reads 0 while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            issue_cnt_q  <= '0;
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            inflight_q   <= 1'b0;
            out_vld_q    <= 1'b0;
            spare_vld_q  <= 1'b0;
            out_data_q   <= '0;
            spare_data_q <= '0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            inflight_q   <= pop;
            out_vld_q    <= out_vld_d;
            spare_vld_q  <= spare_vld_d;
            out_data_q   <= out_data_d;
            spare_data_q <= spare_data_d;
        end
    end

    // NOTE: every always_comb output gets its default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (pop && issue_cnt_q == ISS_W'(TOTAL_BEATS - 1)) state_d = S_DRAIN;
            S_DRAIN: if (frame_end) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        if (start_acc) begin
            issue_cnt_d = '0;
        end else if (pop) begin
            issue_cnt_d = issue_cnt_q + 1'b1;
        end
        if (frame_end) begin
            col_cnt_d = '0;
            row_cnt_d = '0;
        end else if (hs && last_col) begin
            col_cnt_d = '0;
            row_cnt_d = row_cnt_q + 1'b1;
        end else if (hs) begin
            col_cnt_d = col_cnt_q + 1'b1;
        end
    end

    // Skid staging: the spare only fills while the output register is occupied and not draining.
    always_comb begin
        out_vld_d    = out_vld_q;
        out_data_d   = out_data_q;
        spare_vld_d  = spare_vld_q;
        spare_data_d = spare_data_q;
        if (hs) begin
            if (spare_vld_q) begin
                out_data_d   = spare_data_q;
                spare_vld_d  = inflight_q;
                spare_data_d = bus.buf_rdata;
            end else begin
                out_vld_d  = inflight_q;
                out_data_d = bus.buf_rdata;
            end
        end else if (inflight_q) begin
            if (!out_vld_q) begin
                out_vld_d  = 1'b1;
                out_data_d = bus.buf_rdata;
            end else begin
                spare_vld_d  = 1'b1;
                spare_data_d = bus.buf_rdata;
            end
        end
    end

    assign bus.buf_rd        = pop;
    assign bus.m_axis_tvalid = out_vld_q;
    assign bus.m_axis_tdata  = out_data_q;
    assign bus.m_axis_tlast  = out_vld_q & last_col;
    assign bus.m_axis_tuser  = out_vld_q & (col_cnt_q == '0) & (row_cnt_q == '0);
    assign busy              = (state_q != S_IDLE);
    assign frame_done        = (state_q == S_DONE);

`ifdef AC_OSTREAM_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if (busy && out_vld_q && !bus.m_axis_tready && !(&stall_q)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif
endmodule
